// File: rtl/proc_test_pkg.sv
// Shared types and defaults for the core run sequencer and its watchdog.
package proc_test_pkg;

    localparam int unsigned PCW_DEF = 64;
    localparam int unsigned DW_DEF  = 64;
    localparam int unsigned CNT_W   = 16;

    localparam logic [CNT_W-1:0] WDOG_MAX_DEF = 16'hFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RESET  = 3'd1,
        ST_RUN    = 3'd2,
        ST_SETTLE = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5
    } run_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/proc_run_controller_run_watchdog.sv
// Per-run watchdog: counts enabled cycles and flags when the limit is reached.
module run_watchdog
    import proc_test_pkg::*;
#(
    parameter logic [CNT_W-1:0] LIMIT = WDOG_MAX_DEF
) (
    input  logic CLK,
    input  logic resetl,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired_c
);

    logic [CNT_W-1:0] r_count;

    // Count enabled cycles, parking at the limit so the flag stays asserted.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LIMIT)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expired_c = (r_count == LIMIT);

endmodule

// File: rtl/proc_run_controller.sv
// Run sequencer for the single-cycle core: reset with a start PC, run to an end
// address, let the data memory settle one cycle, then compare against a pass code.
module proc_run_controller
    import proc_test_pkg::*;
#(
    parameter int unsigned      PCW        = PCW_DEF,
    parameter int unsigned      DW         = DW_DEF,
    parameter int unsigned      RST_CYCLES = 1,
    parameter logic [CNT_W-1:0] WDOG_MAX   = WDOG_MAX_DEF
) (
    input  logic             CLK,
    input  logic             resetl,
    input  logic             start,
    input  logic             cont,
    input  logic [PCW-1:0]   start_pc,
    input  logic [PCW-1:0]   end_pc,
    input  logic [DW-1:0]    expected,
    input  logic [PCW-1:0]   currentpc,
    input  logic [DW-1:0]    dmemout,
    output logic             core_resetl,
    output logic [PCW-1:0]   core_startpc,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [DW-1:0]    result,
    output logic [CNT_W-1:0] cycles
);

    run_state_e       r_state;
    logic [PCW-1:0]   r_end_pc;
    logic [DW-1:0]    r_expected;
    logic [CNT_W-1:0] r_rst_cnt;
    logic             r_core_resetl;
    logic [PCW-1:0]   r_core_startpc;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic             r_timeout;
    logic [DW-1:0]    r_result;
    logic [CNT_W-1:0] r_cycles;

    logic w_accept;
    logic w_running;
    logic w_end_hit;
    logic w_wd_expired;

    // A start is only honoured when no run is in flight.
    assign w_accept  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_running = (r_state == ST_RUN) || (r_state == ST_SETTLE);
    assign w_end_hit = (currentpc >= r_end_pc);

    run_watchdog #(
        .LIMIT (WDOG_MAX)
    ) u_watchdog (
        .CLK         (CLK),
        .resetl      (resetl),
        .i_clear     (w_accept),
        .i_enable    (w_running),
        .o_expired_c (w_wd_expired)
    );

    // Sequencer state, latched run parameters and all registered outputs.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            r_state        <= ST_IDLE;
            r_end_pc       <= '0;
            r_expected     <= '0;
            r_rst_cnt      <= '0;
            r_core_resetl  <= 1'b0;
            r_core_startpc <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_pass         <= 1'b0;
            r_timeout      <= 1'b0;
            r_result       <= '0;
            r_cycles       <= '0;
        end else begin
            if (w_running) begin
                r_cycles <= sat_inc(r_cycles);
            end

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_end_pc   <= end_pc;
                        r_expected <= expected;
                        r_cycles   <= '0;
                        r_pass     <= 1'b0;
                        r_timeout  <= 1'b0;
                        r_done     <= 1'b0;
                        r_busy     <= 1'b1;
                        if (cont && (r_state == ST_DONE)) begin
                            // Continue: core keeps running from where it is.
                            r_state <= ST_RUN;
                        end else begin
                            r_core_startpc <= start_pc;
                            r_core_resetl  <= 1'b0;
                            r_rst_cnt      <= '0;
                            r_state        <= ST_RESET;
                        end
                    end
                end

                ST_RESET: begin
                    if (r_rst_cnt == CNT_W'(RST_CYCLES - 1)) begin
                        r_core_resetl <= 1'b1;
                        r_state       <= ST_RUN;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + CNT_W'(1);
                    end
                end

                ST_RUN: begin
                    // Reaching the end address wins over a simultaneous expiry.
                    if (w_end_hit) begin
                        r_state <= ST_SETTLE;
                    end else if (w_wd_expired) begin
                        r_timeout <= 1'b1;
                        r_pass    <= 1'b0;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= ST_DONE;
                    end
                end

                ST_SETTLE: begin
                    if (w_wd_expired) begin
                        r_timeout <= 1'b1;
                        r_pass    <= 1'b0;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= ST_DONE;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    r_result <= dmemout;
                    r_pass   <= (dmemout == r_expected);
                    r_done   <= 1'b1;
                    r_state  <= ST_DONE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign core_resetl  = r_core_resetl;
    assign core_startpc = r_core_startpc;
    assign busy         = r_busy;
    assign done         = r_done;
    assign pass         = r_pass;
    assign timeout      = r_timeout;
    assign result       = r_result;
    assign cycles       = r_cycles;

endmodule

// File: tb/tb_proc_run_controller.sv
// Self-checking bench for proc_run_controller with a simple +4-per-cycle core model.
module tb_proc_run_controller;
    import proc_test_pkg::*;

    localparam int unsigned PCW = 64;
    localparam int unsigned DW  = 64;

    logic           clk = 1'b0;
    logic           resetl;
    logic           start;
    logic           cont;
    logic [PCW-1:0] start_pc;
    logic [PCW-1:0] end_pc;
    logic [DW-1:0]  expected;
    logic [PCW-1:0] currentpc;
    logic [DW-1:0]  dmemout;
    logic           core_resetl;
    logic [PCW-1:0] core_startpc;
    logic           busy;
    logic           done;
    logic           pass;
    logic           timeout;
    logic [DW-1:0]  result;
    logic [15:0]    cycles;

    logic [PCW-1:0] m_pc;
    logic [DW-1:0]  m_dm;

    typedef struct packed {
        logic        pass;
        logic        timeout;
        logic [63:0] result;
        logic [15:0] cycles;
        logic        chk_cycles;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en   = 1'b0;
    int   low_cnt  = 0;

    always #5 clk = ~clk;

    // Core model: PC loads startpc while in reset, then advances by 4 per cycle.
    always @(posedge clk) begin
        if (!core_resetl) m_pc <= core_startpc;
        else              m_pc <= m_pc + 64'd4;
    end
    assign currentpc = m_pc;
    assign dmemout   = m_dm;

    // Counts cycles where the core reset is asserted while monitoring a continued run.
    always @(negedge clk) begin
        if (mon_en && (core_resetl !== 1'b1)) low_cnt++;
    end

    proc_run_controller #(
        .PCW        (PCW),
        .DW         (DW),
        .RST_CYCLES (1),
        .WDOG_MAX   (WDOG_MAX_DEF)
    ) dut (
        .CLK          (clk),
        .resetl       (resetl),
        .start        (start),
        .cont         (cont),
        .start_pc     (start_pc),
        .end_pc       (end_pc),
        .expected     (expected),
        .currentpc    (currentpc),
        .dmemout      (dmemout),
        .core_resetl  (core_resetl),
        .core_startpc (core_startpc),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .timeout      (timeout),
        .result       (result),
        .cycles       (cycles)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input logic [63:0] sp, input logic [63:0] ep,
                               input logic [63:0] ex, input logic c);
        start_pc = sp; end_pc = ep; expected = ex; cont = c; start = 1'b1;
        tick();
        start = 1'b0; cont = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int n;
        n = 0;
        while ((done !== 1'b1) && (n < budget)) begin
            tick();
            n++;
        end
        ok = (done === 1'b1);
    endtask

    task automatic test_reset();
        resetl = 1'b1; start = 1'b0; cont = 1'b0;
        start_pc = '0; end_pc = '0; expected = '0; m_dm = '0;
        #2 resetl = 1'b0;
        #1;
        n_checks++;
        if ({core_resetl, busy, done, pass, timeout} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_flags got %b required 00000", {core_resetl, busy, done, pass, timeout});
        end
        n_checks++;
        if (core_startpc !== '0) begin
            n_errors++; $display("FAIL reset_startpc got %h required 0", core_startpc);
        end
        n_checks++;
        if (result !== '0) begin
            n_errors++; $display("FAIL reset_result got %h required 0", result);
        end
        n_checks++;
        if (cycles !== 16'h0) begin
            n_errors++; $display("FAIL reset_cycles got %h required 0", cycles);
        end
        repeat (2) tick();
        resetl = 1'b1;
        tick();
    endtask

    task automatic test_pass_run();
        bit   ok;
        exp_t e;
        m_dm = 64'hF;
        drive_start(64'h0, 64'h34, 64'hF, 1'b0);
        sb.push_back('{pass: 1'b1, timeout: 1'b0, result: 64'hF, cycles: 16'h000F, chk_cycles: 1'b1});
        n_checks++;
        if ({busy, core_resetl} !== 2'b10) begin
            n_errors++; $display("FAIL pass_run_in_reset busy,core_resetl got %b required 10", {busy, core_resetl});
        end
        tick();
        n_checks++;
        if (core_resetl !== 1'b1) begin
            n_errors++; $display("FAIL pass_run_release core_resetl got %b required 1", core_resetl);
        end
        wait_done(100, ok);
        n_checks++;
        if (!ok) begin
            n_errors++; $display("FAIL pass_run_done got %b required 1", done);
        end
        e = sb.pop_front();
        n_checks++;
        if ({pass, timeout, result} !== {e.pass, e.timeout, e.result}) begin
            n_errors++;
            $display("FAIL pass_run_result got p=%b t=%b r=%h required p=%b t=%b r=%h",
                     pass, timeout, result, e.pass, e.timeout, e.result);
        end
        n_checks++;
        if (cycles !== e.cycles) begin
            n_errors++; $display("FAIL pass_run_cycles got %h required %h", cycles, e.cycles);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++; $display("FAIL pass_run_busy got %b required 0", busy);
        end
    endtask

    task automatic test_continue();
        bit          ok;
        exp_t        e;
        logic [63:0] p;
        logic [15:0] exp_cyc;
        m_dm    = 64'h1234_5678_9abc_def0;
        low_cnt = 0;
        mon_en  = 1'b1;
        drive_start(64'h1000, 64'h5C, 64'h1234_5678_9abc_def0, 1'b1);
        p = m_pc;
        if (p >= 64'h5C) exp_cyc = 16'd2;
        else             exp_cyc = 16'(((64'h5C - p) + 64'd3) / 64'd4 + 64'd2);
        sb.push_back('{pass: 1'b1, timeout: 1'b0, result: 64'h1234_5678_9abc_def0,
                       cycles: exp_cyc, chk_cycles: 1'b1});
        n_checks++;
        if (core_startpc !== 64'h0) begin
            n_errors++; $display("FAIL cont_startpc got %h required 0", core_startpc);
        end
        wait_done(100, ok);
        mon_en = 1'b0;
        n_checks++;
        if (!ok) begin
            n_errors++; $display("FAIL cont_done got %b required 1", done);
        end
        n_checks++;
        if (low_cnt != 0) begin
            n_errors++; $display("FAIL cont_no_core_reset low cycles %0d required 0", low_cnt);
        end
        e = sb.pop_front();
        n_checks++;
        if ({pass, timeout, result} !== {e.pass, e.timeout, e.result}) begin
            n_errors++;
            $display("FAIL cont_result got p=%b t=%b r=%h required p=%b t=%b r=%h",
                     pass, timeout, result, e.pass, e.timeout, e.result);
        end
        n_checks++;
        if (e.chk_cycles && (cycles !== e.cycles)) begin
            n_errors++; $display("FAIL cont_cycles got %h required %h", cycles, e.cycles);
        end
    endtask

    task automatic test_fail_run();
        bit   ok;
        exp_t e;
        m_dm = 64'hE;
        drive_start(64'h0, 64'h34, 64'hF, 1'b0);
        sb.push_back('{pass: 1'b0, timeout: 1'b0, result: 64'hE, cycles: 16'h000F, chk_cycles: 1'b1});
        n_checks++;
        if (core_resetl !== 1'b0) begin
            n_errors++; $display("FAIL fail_run_core_reset got %b required 0", core_resetl);
        end
        wait_done(100, ok);
        n_checks++;
        if (!ok) begin
            n_errors++; $display("FAIL fail_run_done got %b required 1", done);
        end
        e = sb.pop_front();
        n_checks++;
        if ({pass, timeout, result} !== {e.pass, e.timeout, e.result}) begin
            n_errors++;
            $display("FAIL fail_run_result got p=%b t=%b r=%h required p=%b t=%b r=%h",
                     pass, timeout, result, e.pass, e.timeout, e.result);
        end
        n_checks++;
        if (cycles !== e.cycles) begin
            n_errors++; $display("FAIL fail_run_cycles got %h required %h", cycles, e.cycles);
        end
    endtask

    task automatic test_timeout();
        bit   ok;
        exp_t e;
        int   n;
        m_dm = 64'hF;
        drive_start(64'h100, 64'hFFFF_FFFF, 64'hF, 1'b0);
        sb.push_back('{pass: 1'b0, timeout: 1'b1, result: 64'hE, cycles: 16'h0, chk_cycles: 1'b0});
        n = 0;
        while ((done !== 1'b1) && (n < 400)) begin
            tick();
            n++;
        end
        ok = (done === 1'b1);
        n_checks++;
        if (!ok || (n < int'(WDOG_MAX_DEF))) begin
            n_errors++; $display("FAIL timeout_done done=%b after %0d cycles required 1 after >= %0d",
                                 done, n, int'(WDOG_MAX_DEF));
        end
        e = sb.pop_front();
        n_checks++;
        if ({pass, timeout, result} !== {e.pass, e.timeout, e.result}) begin
            n_errors++;
            $display("FAIL timeout_result got p=%b t=%b r=%h required p=%b t=%b r=%h",
                     pass, timeout, result, e.pass, e.timeout, e.result);
        end
    endtask

    task automatic test_start_ignored();
        bit   ok;
        exp_t e;
        m_dm = 64'hF;
        drive_start(64'h0, 64'h34, 64'hF, 1'b0);
        sb.push_back('{pass: 1'b1, timeout: 1'b0, result: 64'hF, cycles: 16'h000F, chk_cycles: 1'b1});
        repeat (4) tick();
        end_pc = 64'h80; expected = 64'h0; cont = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; cont = 1'b0;
        n_checks++;
        if ({busy, done} !== 2'b10) begin
            n_errors++; $display("FAIL ignored_start busy,done got %b required 10", {busy, done});
        end
        wait_done(100, ok);
        n_checks++;
        if (!ok) begin
            n_errors++; $display("FAIL ignored_done got %b required 1", done);
        end
        e = sb.pop_front();
        n_checks++;
        if ({pass, timeout, result} !== {e.pass, e.timeout, e.result}) begin
            n_errors++;
            $display("FAIL ignored_result got p=%b t=%b r=%h required p=%b t=%b r=%h",
                     pass, timeout, result, e.pass, e.timeout, e.result);
        end
        n_checks++;
        if (cycles !== e.cycles) begin
            n_errors++; $display("FAIL ignored_cycles got %h required %h", cycles, e.cycles);
        end
    endtask

    task automatic test_async_reset();
        bit   ok;
        exp_t e;
        drive_start(64'h200, 64'h234, 64'hF, 1'b0);
        repeat (3) tick();
        n_checks++;
        if ({busy, core_resetl, core_startpc} !== {2'b11, 64'h200}) begin
            n_errors++; $display("FAIL async_pre_run busy=%b core_resetl=%b startpc=%h required 1 1 200",
                                 busy, core_resetl, core_startpc);
        end
        #2 resetl = 1'b0;
        #1;
        n_checks++;
        if ({core_resetl, busy, done, pass, timeout, result, cycles, core_startpc} !== '0) begin
            n_errors++;
            $display("FAIL async_reset got rl=%b b=%b d=%b p=%b t=%b r=%h c=%h sp=%h required all 0",
                     core_resetl, busy, done, pass, timeout, result, cycles, core_startpc);
        end
        tick();
        n_checks++;
        if ({busy, core_resetl} !== 2'b00) begin
            n_errors++; $display("FAIL async_hold busy,core_resetl got %b required 00", {busy, core_resetl});
        end
        resetl = 1'b1;
        tick();
        // Back-to-back run from IDLE after the abort.
        drive_start(64'h200, 64'h234, 64'hF, 1'b0);
        sb.push_back('{pass: 1'b1, timeout: 1'b0, result: 64'hF, cycles: 16'h000F, chk_cycles: 1'b1});
        wait_done(100, ok);
        n_checks++;
        if (!ok) begin
            n_errors++; $display("FAIL after_reset_done got %b required 1", done);
        end
        e = sb.pop_front();
        n_checks++;
        if ({pass, timeout, result, cycles} !== {e.pass, e.timeout, e.result, e.cycles}) begin
            n_errors++;
            $display("FAIL after_reset_result got p=%b t=%b r=%h c=%h required p=%b t=%b r=%h c=%h",
                     pass, timeout, result, cycles, e.pass, e.timeout, e.result, e.cycles);
        end
    endtask

    initial begin
        test_reset();
        test_pass_run();
        repeat (2) tick();
        test_continue();
        test_fail_run();
        test_timeout();
        test_start_ignored();
        test_async_reset();
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++; $display("FAIL scoreboard_leftover entries %0d required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
